// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: pixel coordinates plus sync/blank state, all aligned
// to one another. The generator drives it; renderers observe it.
interface vga_sync_gen_if;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pixel_tick;
  logic       frame_start;

  modport master (
    output HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );

  modport slave (
    input HCount, VCount, hsync, vsync, video_on, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: halves clk into a pixel-tick enable and runs
// the line/frame counters with registered, mutually aligned sync and blank flags.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic             div_q, div_d;
  logic [CNT_W-1:0] h_count_q, h_count_d;
  logic [CNT_W-1:0] v_count_q, v_count_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;

  // Next-state counters; sync/blank flags derive from the next counter values
  // so they land in the same cycle as the coordinate they describe.
  always_comb begin
    div_d         = ~div_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    frame_start_d = 1'b0;

    if (div_q) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        if (v_count_q == V_LAST) begin
          v_count_d     = '0;
          frame_start_d = 1'b1;
        end else begin
          v_count_d = v_count_q + CNT_W'(1);
        end
      end else begin
        h_count_d = h_count_q + CNT_W'(1);
      end
    end

    hsync_d    = !((h_count_d >= HS_FIRST) && (h_count_d <= HS_LAST));
    vsync_d    = !((v_count_d >= VS_FIRST) && (v_count_d <= VS_LAST));
    video_on_d = (h_count_d < H_VIS) && (v_count_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= 1'b0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  // The divider flop is the pixel-tick register itself.
  assign vga.pixel_tick  = div_q;
  assign vga.HCount      = h_count_q;
  assign vga.VCount      = v_count_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: dut_a runs default 640x480 timing, dut_b a short raster
// (400-tick line, 15-line frame) so whole frames fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       fs;
  } snap_t;

  typedef struct {
    int unsigned cyc;
    snap_t       s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #10 clk = ~clk;

  vga_sync_gen_if vif_a ();
  vga_sync_gen_if vif_b ();

  vga_sync_gen dut_a (.clk(clk), .reset(rst_a), .vga(vif_a));

  vga_sync_gen #(
    .H_DISPLAY(320), .H_FRONT(8), .H_SYNC(48), .H_BACK(24),
    .V_DISPLAY(8),   .V_FRONT(2), .V_SYNC(2),  .V_BACK(3)
  ) dut_b (.clk(clk), .reset(rst_b), .vga(vif_b));

  exp_t  qa[$], qb[$];
  string na[$], nb[$];

  int unsigned cyc = 0;
  int unsigned base = 0, base2 = 0;
  bit          started = 1'b0;
  int          checks = 0, fails = 0;

  int a_hs_low = 0, a_vid = 0, a_viol = 0;
  int b_vid = 0, b_viol = 0, b_vs_low = 0, b_vs_bad = 0, b_wraps = 0, b_hs_low = 0;
  int b_fs_cnt = 0, b_fs_off = 0;
  int unsigned fs_first = 0, fs_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t mk(input int h, input int v, input logic hs, input logic vs,
                               input logic von, input logic pt, input logic fs);
    snap_t r;
    r.hc = 10'(h); r.vc = 10'(v);
    r.hs = hs; r.vs = vs; r.von = von; r.pt = pt; r.fs = fs;
    return r;
  endfunction

  task automatic push_a(input string n, input int unsigned at, input snap_t s);
    exp_t e;
    e.cyc = at; e.s = s;
    qa.push_back(e); na.push_back(n);
  endtask

  task automatic push_b(input string n, input int unsigned at, input snap_t s);
    exp_t e;
    e.cyc = at; e.s = s;
    qb.push_back(e); nb.push_back(n);
  endtask

  task automatic cmp(input string n, input int unsigned at, input snap_t act, input snap_t ex);
    checks++;
    if (at != cyc || act !== ex) begin
      fails++;
      $display("FAIL %s @cyc %0d (due %0d): got H=%0d V=%0d hs=%b vs=%b von=%b pt=%b fs=%b, required H=%0d V=%0d hs=%b vs=%b von=%b pt=%b fs=%b",
               n, cyc, at, act.hc, act.vc, act.hs, act.vs, act.von, act.pt, act.fs,
               ex.hc, ex.vc, ex.hs, ex.vs, ex.von, ex.pt, ex.fs);
    end
  endtask

  task automatic agg(input string n, input int act, input int ex);
    checks++;
    if (act != ex) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", n, act, ex);
    end
  endtask

  // Monitor: pops due expectations and accumulates per-line/per-frame counts.
  always @(negedge clk) begin
    snap_t act_a, act_b;
    act_a = {vif_a.HCount, vif_a.VCount, vif_a.hsync, vif_a.vsync,
             vif_a.video_on, vif_a.pixel_tick, vif_a.frame_start};
    act_b = {vif_b.HCount, vif_b.VCount, vif_b.hsync, vif_b.vsync,
             vif_b.video_on, vif_b.pixel_tick, vif_b.frame_start};
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      cmp(na[0], qa[0].cyc, act_a, qa[0].s);
      void'(qa.pop_front()); void'(na.pop_front());
    end
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      cmp(nb[0], qb[0].cyc, act_b, qb[0].s);
      void'(qb.pop_front()); void'(nb.pop_front());
    end
    if (started) begin
      if (cyc > base && cyc <= base + 1600) begin
        if (!vif_a.hsync) a_hs_low++;
        if (vif_a.pixel_tick && vif_a.video_on) a_vid++;
        if (vif_a.video_on && (vif_a.HCount >= 640 || vif_a.VCount >= 480)) a_viol++;
      end
      if (cyc >= base + 12000 && cyc < base + 24000) begin
        if (vif_b.pixel_tick && vif_b.video_on) b_vid++;
        if (vif_b.video_on && (vif_b.HCount >= 320 || vif_b.VCount >= 8)) b_viol++;
        if (!vif_b.vsync) b_vs_low++;
        if (!vif_b.hsync) b_hs_low++;
        if (vif_b.vsync != !(vif_b.VCount == 10 || vif_b.VCount == 11)) b_vs_bad++;
        if (vif_b.HCount == 0 && !vif_b.pixel_tick) b_wraps++;
      end
      if (cyc > base && cyc <= base + 33500 && vif_b.frame_start) begin
        b_fs_cnt++;
        if (b_fs_cnt == 1) fs_first = cyc;
        fs_last = cyc;
        if (vif_b.HCount != 0 || vif_b.VCount != 0) b_fs_off++;
      end
    end
  end

  initial begin
    snap_t rst_s;
    rst_s = mk(0, 0, 1, 1, 0, 0, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push_a("a_in_reset", i, rst_s);
      push_b("b_in_reset", i, rst_s);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    base = cyc;
    started = 1'b1;

    push_a("a_k1",          base + 1,    mk(0,   0, 1, 1, 1, 1, 0));
    push_a("a_k2",          base + 2,    mk(1,   0, 1, 1, 1, 0, 0));
    push_a("a_k3",          base + 3,    mk(1,   0, 1, 1, 1, 1, 0));
    push_a("a_k4",          base + 4,    mk(2,   0, 1, 1, 1, 0, 0));
    push_a("a_last_vis",    base + 1279, mk(639, 0, 1, 1, 1, 1, 0));
    push_a("a_first_blank", base + 1280, mk(640, 0, 1, 1, 0, 0, 0));
    push_a("a_pre_hsync",   base + 1311, mk(655, 0, 1, 1, 0, 1, 0));
    push_a("a_hsync_fall",  base + 1312, mk(656, 0, 0, 1, 0, 0, 0));
    push_a("a_hsync_last",  base + 1503, mk(751, 0, 0, 1, 0, 1, 0));
    push_a("a_hsync_rise",  base + 1504, mk(752, 0, 1, 1, 0, 0, 0));
    push_a("a_line_end",    base + 1599, mk(799, 0, 1, 1, 0, 1, 0));
    push_a("a_line_wrap",   base + 1600, mk(0,   1, 1, 1, 1, 0, 0));
    push_a("a_line2_wrap",  base + 3200, mk(0,   2, 1, 1, 1, 0, 0));

    push_b("b_k1",          base + 1,     mk(0,   0,  1, 1, 1, 1, 0));
    push_b("b_k2",          base + 2,     mk(1,   0,  1, 1, 1, 0, 0));
    push_b("b_pre_hsync",   base + 655,   mk(327, 0,  1, 1, 0, 1, 0));
    push_b("b_hsync_fall",  base + 656,   mk(328, 0,  0, 1, 0, 0, 0));
    push_b("b_hsync_last",  base + 751,   mk(375, 0,  0, 1, 0, 1, 0));
    push_b("b_hsync_rise",  base + 752,   mk(376, 0,  1, 1, 0, 0, 0));
    push_b("b_line_end",    base + 799,   mk(399, 0,  1, 1, 0, 1, 0));
    push_b("b_line_wrap",   base + 800,   mk(0,   1,  1, 1, 1, 0, 0));
    push_b("b_pre_vsync",   base + 7999,  mk(399, 9,  1, 1, 0, 1, 0));
    push_b("b_vsync_fall",  base + 8000,  mk(0,   10, 1, 0, 0, 0, 0));
    push_b("b_vsync_line2", base + 8800,  mk(0,   11, 1, 0, 0, 0, 0));
    push_b("b_vsync_rise",  base + 9600,  mk(0,   12, 1, 1, 0, 0, 0));
    push_b("b_frame_end",   base + 11999, mk(399, 14, 1, 1, 0, 1, 0));
    push_b("b_frame_start", base + 12000, mk(0,   0,  1, 1, 1, 0, 1));
    push_b("b_after_fs",    base + 12001, mk(0,   0,  1, 1, 1, 1, 0));
    push_b("b_fs2",         base + 24000, mk(0,   0,  1, 1, 1, 0, 1));
    push_b("b_mid_frame",   base + 33500, mk(350, 11, 0, 0, 0, 0, 0));

    // One-clk reset in the middle of both sync pulses on dut_b.
    while (cyc != base + 33500) @(negedge clk);
    rst_b = 1'b1;
    push_b("b_mid_reset", base + 33501, rst_s);
    @(negedge clk);
    rst_b = 1'b0;
    base2 = cyc;
    push_b("b_resume_k1",    base2 + 1,   mk(0,   0, 1, 1, 1, 1, 0));
    push_b("b_resume_k2",    base2 + 2,   mk(1,   0, 1, 1, 1, 0, 0));
    push_b("b_resume_hsync", base2 + 656, mk(328, 0, 0, 1, 0, 0, 0));
    push_b("b_resume_wrap",  base2 + 800, mk(0,   1, 1, 1, 1, 0, 0));
    while (cyc != base2 + 810) @(negedge clk);
    @(negedge clk);

    agg("a_hsync_low_clk",   a_hs_low, 192);
    agg("a_video_ticks",     a_vid,    640);
    agg("a_video_violation", a_viol,   0);
    agg("b_video_ticks",     b_vid,    2560);
    agg("b_video_violation", b_viol,   0);
    agg("b_vsync_low_clk",   b_vs_low, 1600);
    agg("b_vsync_vs_vcount", b_vs_bad, 0);
    agg("b_hsync_low_clk",   b_hs_low, 1440);
    agg("b_lines_per_frame", b_wraps,  15);
    agg("b_frame_pulses",    b_fs_cnt, 2);
    agg("b_frame_period",    int'(fs_last - fs_first), 12000);
    agg("b_fs_not_origin",   b_fs_off, 0);
    agg("queues_drained",    qa.size() + qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
